// File: rtl/lza_pipe_param.sv
// rtl/lza_pipe_param.sv - two-stage pipelined leading-zero anticipator with valid/ready flow control
// Optional macro LZA_CORR_EN: registers the sum, corrects the 1-bit anticipation error, adds port corr.
module lza_pipe_param #(
    parameter int W = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(W)-1:0] lzc,
    output logic                 e_zero
`ifdef LZA_CORR_EN
    ,
    output logic                 corr
`endif
);
    localparam int CW = $clog2(W);
    localparam int P  = 1 << CW;

    logic         adv1;
    logic         adv2;
    logic         s1_valid;
    logic         s2_valid;
    logic [W-1:0] e_ind;
    logic [W-1:0] s1_e;
    logic [P-1:0] e_pad;
    logic [CW-1:0] m_idx;
    logic [CW-1:0] lzc_raw;
    logic [CW-1:0] lzc_nxt;
    logic          ezero_nxt;

    // Handshake: a stage may load whenever it is empty or the stage after it is moving.
    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    always_comb begin
        e_ind    = '0;
        e_ind[0] = 1'b1;
        for (int i = 1; i < W; i++) begin
            e_ind[i] = (a[i] ~^ b[i]) & (a[i-1] | b[i-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_e     <= W'(1);
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_e <= e_ind;
            end
        end
    end

    // Bottom-up pairwise tree: each node keeps the index of its highest set leaf,
    // the upper child winning whenever it holds any set bit.
    function automatic logic [CW-1:0] hi_index(input logic [P-1:0] v_in);
        logic [P-1:0]  v;
        logic [CW-1:0] ix [P];
        v = v_in;
        for (int i = 0; i < P; i++) begin
            ix[i] = '0;
        end
        for (int l = 0; l < CW; l++) begin
            for (int n = 0; n < (P >> (l + 1)); n++) begin
                if (v[2*n+1]) begin
                    v[n]  = 1'b1;
                    ix[n] = ix[2*n+1] | CW'(1 << l);
                end else begin
                    v[n]  = v[2*n];
                    ix[n] = ix[2*n];
                end
            end
        end
        return ix[0];
    endfunction

    assign e_pad     = P'(s1_e);
    assign m_idx     = hi_index(e_pad);
    assign lzc_raw   = CW'(W - 1) - m_idx;
    assign ezero_nxt = ~|s1_e[W-1:1];

`ifdef LZA_CORR_EN
    logic [W-1:0] s1_s;
    logic         corr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_s <= '0;
        end else if (adv1 && in_valid) begin
            s1_s <= a + b;
        end
    end

    // S[W-1-p] is S[m]; a zero there means the anticipated position is one too high.
    assign corr_nxt = (m_idx != '0) && !s1_s[m_idx];
    assign lzc_nxt  = lzc_raw + CW'(corr_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr <= 1'b0;
        end else if (adv2 && s1_valid) begin
            corr <= corr_nxt;
        end
    end
`else
    assign lzc_nxt = lzc_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            lzc      <= '0;
            e_zero   <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                lzc    <= lzc_nxt;
                e_zero <= ezero_nxt;
            end
        end
    end

endmodule

// File: tb/tb_lza_pipe_param.sv
// tb/tb_lza_pipe_param.sv - table-driven bench for lza_pipe_param, W=27
module tb_lza_pipe_param;
    localparam int W  = 27;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] lzc;
    logic          e_zero;
`ifdef LZA_CORR_EN
    logic          corr;
`endif

    lza_pipe_param #(.W(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .lzc(lzc),
        .e_zero(e_zero)
`ifdef LZA_CORR_EN
        ,
        .corr(corr)
`endif
    );

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [CW-1:0] lzc;
        logic          zero;
        logic [CW-1:0] lzc_c;
        logic          corr;
        string         name;
    } vec_t;

    typedef struct {
        logic [CW-1:0] lzc;
        logic          zero;
        logic          corr;
        int            acc_cyc;
        bit            lat_chk;
        string         name;
    } exp_t;

    vec_t tv [9];
    exp_t expq [$];
    int   rxq [$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stalls = 0;
    int   base;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [CW-1:0] exp_lzc(input int idx);
`ifdef LZA_CORR_EN
        return tv[idx].lzc_c;
`else
        return tv[idx].lzc;
`endif
    endfunction

    task automatic send(input int idx, input bit lat);
        exp_t e;
        a        = tv[idx].a;
        b        = tv[idx].b;
        in_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.lzc     = exp_lzc(idx);
                e.zero    = tv[idx].zero;
                e.corr    = tv[idx].corr;
                e.acc_cyc = cyc;
                e.lat_chk = lat;
                e.name    = tv[idx].name;
                expq.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            stalls = stalls + 1;
            @(posedge clk);
            #1;
        end
        check("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 40; k++) begin
            if (expq.size() == 0) return;
            @(posedge clk);
            #1;
        end
        check({"drain_timeout_", name}, expq.size(), 0);
    endtask

    initial begin
        tv[0] = '{27'h2000000, 27'h2000000,  0, 1'b0,  0, 1'b0, "t1_msb"};
        tv[1] = '{27'h0000001, 27'h0000001, 25, 1'b0, 25, 1'b0, "t2_one"};
        tv[2] = '{27'h0000000, 27'h0000000, 26, 1'b1, 26, 1'b0, "t2_zero"};
        tv[3] = '{27'h0000003, 27'h0000000, 24, 1'b0, 25, 1'b1, "t3_corr"};
        tv[4] = '{27'h7FFFFFF, 27'h0000000, 26, 1'b1, 26, 1'b0, "all_prop"};
        tv[5] = '{27'h0400000, 27'h0400000,  3, 1'b0,  3, 1'b0, "bit22"};
        tv[6] = '{27'h0000010, 27'h0000010, 21, 1'b0, 21, 1'b0, "bit4"};
        tv[7] = '{27'h0000005, 27'h0000002, 23, 1'b0, 24, 1'b1, "mix_corr"};
        tv[8] = '{27'h4000000, 27'h0000000, 26, 1'b1, 26, 1'b0, "top_only"};

        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        mon_e = expq.pop_front();
                        check({"lzc_", mon_e.name}, 32'(lzc), 32'(mon_e.lzc));
                        check({"e_zero_", mon_e.name}, 32'(e_zero), 32'(mon_e.zero));
`ifdef LZA_CORR_EN
                        check({"corr_", mon_e.name}, 32'(corr), 32'(mon_e.corr));
`endif
                        if (mon_e.lat_chk)
                            check({"latency_", mon_e.name}, cyc - mon_e.acc_cyc, 2);
                        rxq.push_back(cyc);
                    end
                end
            end
        join_none

        // Reset state
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_lzc", 32'(lzc), 0);
        check("rst_e_zero", 32'(e_zero), 0);
`ifdef LZA_CORR_EN
        check("rst_corr", 32'(corr), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 32'(in_ready), 1);

        // Latency of a single transfer
        send(0, 1);
        check("lat_stage1_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        check("lat_stage2_out_valid", 32'(out_valid), 1);
        check("lat_stage2_lzc", 32'(lzc), 0);
        wait_drain("t1");

        // Every vector in isolation
        for (int i = 0; i < 9; i++) begin
            send(i, 1);
            wait_drain(tv[i].name);
        end

        // Back-to-back stream
        rxq.delete();
        stalls = 0;
        for (int i = 0; i < 4; i++) send(i, 1);
        wait_drain("stream");
        check("stream_in_ready_stalls", stalls, 0);
        check("stream_count", rxq.size(), 4);
        if (rxq.size() == 4) begin
            for (int i = 1; i < 4; i++) check("stream_consecutive", rxq[i] - rxq[i-1], 1);
        end

        // Backpressure: fill, hold for 5 cycles, release
        rxq.delete();
        out_ready = 1'b0;
        send(3, 0);
        send(4, 0);
        a        = tv[5].a;
        b        = tv[5].b;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_lzc_stable", 32'(lzc), 32'(exp_lzc(3)));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(5, 0);
        wait_drain("backpressure");
        check("bp_count", rxq.size(), 3);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(0, 0);
        send(1, 0);
        check("pre_rst_full", 32'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 0);
        expq.delete();
        @(posedge clk);
        #1;
        check("rst_hold_lzc", 32'(lzc), 0);
        check("rst_hold_e_zero", 32'(e_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_no_stale", 32'(out_valid), 0);
        out_ready = 1'b1;
        rxq.delete();
        send(6, 1);
        check("post_rst_stage1_idle", 32'(out_valid), 0);
        wait_drain("post_reset");
        check("post_rst_count", rxq.size(), 1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
